// File: rtl/mdu_unit_if.sv
// Request/response bundle between the E-stage issue logic and the multiply/divide unit.
// HI/LO and busy come back to the pipeline for forwarding and stall decisions.
interface mdu_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       MDOp;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (output start, MDOp, A, B, input busy, HI, LO);
    modport slave  (input start, MDOp, A, B, output busy, HI, LO);
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. Results are computed at acceptance,
// held as pending values and committed after a fixed busy window.
module mdu_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic      clk,
    input  logic      reset,
    mdu_unit_if.slave bus
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] phi_q, phi_d, plo_q, plo_d;
    logic             pwe_q, pwe_d;

    logic [2*WIDTH-1:0] mul_s, mulu_s, div_s, divu_s;

    // Sign-magnitude division: avoids the MIN/-1 overflow of a native signed divide.
    // Returns {remainder, quotient}; remainder follows the dividend's sign.
    function automatic logic [2*WIDTH-1:0] div_calc(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b,
                                                    input logic             sgn);
        logic             neg_a, neg_b;
        logic [WIDTH-1:0] ma, mb, q, r;
        neg_a = sgn & a[WIDTH-1];
        neg_b = sgn & b[WIDTH-1];
        ma    = neg_a ? (~a + {{(WIDTH-1){1'b0}}, 1'b1}) : a;
        mb    = neg_b ? (~b + {{(WIDTH-1){1'b0}}, 1'b1}) : b;
        if (mb == {WIDTH{1'b0}}) begin
            q = {WIDTH{1'b0}};
            r = {WIDTH{1'b0}};
        end else begin
            q = ma / mb;
            r = ma % mb;
        end
        q = (neg_a ^ neg_b) ? (~q + {{(WIDTH-1){1'b0}}, 1'b1}) : q;
        r = neg_a ? (~r + {{(WIDTH-1){1'b0}}, 1'b1}) : r;
        return {r, q};
    endfunction

    // Arithmetic results for the operands on the bus this cycle.
    always_comb begin
        mul_s  = {{WIDTH{bus.A[WIDTH-1]}}, bus.A} * {{WIDTH{bus.B[WIDTH-1]}}, bus.B};
        mulu_s = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};
        div_s  = div_calc(bus.A, bus.B, 1'b1);
        divu_s = div_calc(bus.A, bus.B, 1'b0);
    end

    // Next-state: acceptance in IDLE, countdown and commit in RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        pwe_d   = pwe_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    case (bus.MDOp)
                        3'd1, 3'd2: begin
                            {phi_d, plo_d} = (bus.MDOp == 3'd1) ? mul_s : mulu_s;
                            pwe_d   = 1'b1;
                            cnt_d   = CW'(MULT_CYCLES);
                            busy_d  = 1'b1;
                            state_d = RUN;
                        end
                        3'd3, 3'd4: begin
                            {phi_d, plo_d} = (bus.MDOp == 3'd3) ? div_s : divu_s;
                            // A zero divisor still occupies the unit but commits nothing.
                            pwe_d   = (bus.B != {WIDTH{1'b0}});
                            cnt_d   = CW'(DIV_CYCLES);
                            busy_d  = 1'b1;
                            state_d = RUN;
                        end
                        3'd5:    hi_d = bus.A;
                        3'd6:    lo_d = bus.A;
                        default: ;
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (cnt_q == CW'(1)) begin
                    cnt_d   = {CW{1'b0}};
                    busy_d  = 1'b0;
                    state_d = IDLE;
                    if (pwe_q) begin
                        hi_d = phi_q;
                        lo_d = plo_q;
                    end else begin
                        hi_d = hi_q;
                        lo_d = lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and architectural registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b0;
            hi_q    <= {WIDTH{1'b0}};
            lo_q    <= {WIDTH{1'b0}};
            phi_q   <= {WIDTH{1'b0}};
            plo_q   <= {WIDTH{1'b0}};
            pwe_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            pwe_q   <= pwe_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Parametrised multiply/divide unit for the pipelined successor of the single-cycle core; sits beside the ALU in the E stage.
- Owns the HI/LO registers and implements MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Models configurable multi-cycle latency and exposes `busy` so the hazard controller can stall MFHI/MFLO and other MDU instructions.
- Width and latencies are parameters; the single-cycle core had no HI/LO and no multi-cycle operation.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits (legal: 8..64).
- MULT_CYCLES, 5, number of busy cycles for MULT/MULTU (legal: >=1).
- DIV_CYCLES, 10, number of busy cycles for DIV/DIVU (legal: >=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  qualifies MDOp for one cycle.
- MDOp  input  3  operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
- A  input  WIDTH  rs operand.
- B  input  WIDTH  rt operand.
- busy  output  1  high while an operation is in flight.
- HI  output  WIDTH  architectural HI register.
- LO  output  WIDTH  architectural LO register.

Behaviour:
- One clock: clk. Reset is synchronous and active-high: on a clk rising edge with reset=1, HI=0, LO=0, busy=0, counter=0, pending results cleared. Reset wins over every other input.
- States: IDLE, RUN.
- Reset lands in IDLE.
- IDLE accepts a start; RUN ignores all start inputs.
- Accepting an arithmetic op: start=1 with MDOp in 1..4 in IDLE, sampled at edge t.
  - At edge t, latch the operation and compute the pending HI/LO from A and B as sampled at t.
  - At edge t, load the counter with N = MULT_CYCLES or DIV_CYCLES and go to RUN.
- In RUN:
  - busy=1 for exactly N cycles, i.e. the cycles after edges t .. t+N-1.
  - The counter decrements on every edge.
  - At edge t+N, HI/LO take the pending values, busy falls and the state returns to IDLE.
  - New HI/LO are visible in the same cycle that busy is first 0.
- MULT: signed 2·WIDTH-bit product; HI = upper WIDTH bits, LO = lower WIDTH bits. MULTU is the unsigned equivalent.
- DIV (signed):
  - LO = quotient, truncated toward zero.
  - HI = remainder, which takes the sign of the dividend.
  - MIN / -1 gives LO = MIN (wraps), HI = 0.
- DIVU: unsigned quotient and remainder.
- Divide by zero (B=0, DIV or DIVU): the op runs the full DIV_CYCLES with busy, but HI and LO are left unchanged at completion.
- MTHI/MTLO:
  - Accepted in IDLE only.
  - At edge t, HI (or LO) = A.
  - busy is never asserted; the value is visible the next cycle.
- start=1 while in RUN: ignored entirely, no queueing; the in-flight op completes unaffected. The stall logic must prevent this, and the unit must still tolerate it.
- Completing at edge t+N with a new start=1 at the same edge:
  - The new start is ignored, because the state at that edge is RUN.
  - A new op is accepted from edge t+N+1 onward.
  - This gives a 1-cycle minimum gap between back-to-back ops.
- Reset mid-RUN aborts the operation: HI=LO=0 and busy=0 at that edge; the pending result is discarded.
- start=0, or MDOp = 0 or 7: no state change.
- Outputs HI, LO and busy are registered; there is no combinational path from the inputs.

Test Plan:
- Signed multiply: reset, then MULT with A=0xFFFFFFFE (-2), B=3 -> busy high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- Unsigned multiply: MULTU with A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- Signed divide: DIV with A=-7 (0xFFFFFFF9), B=2 -> 10 busy cycles; then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- Overflow divide: DIV with A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero: MTHI A=0x1234 then MTLO A=0x5678 -> HI=0x1234, LO=0x5678 next cycle, busy never high. Then DIVU with B=0 -> 10 busy cycles, and HI/LO are still 0x1234/0x5678.
- Start while busy: MULT A=3, B=4; at busy cycle 2 drive DIV A=100, B=7 -> ignored; the result is HI=0, LO=12 after 5 cycles.
- Reset mid-operation: reset asserted during busy cycle 3 of a DIV -> next cycle busy=0, HI=0, LO=0.
- Back-to-back ops: start asserted continuously -> ops are accepted no more often than every N+1 cycles.
